// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller state encoding, the canonical
// NOP instruction, hold-vector bit positions and the base opcode values used by
// the decode stages.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StDivWait = 2'd2,
    StBusGnt  = 2'd3
  } pipe_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // hold vector is {pc, if_id, id_ex}
  localparam int unsigned HoldPcBit   = 2;
  localparam int unsigned HoldIfIdBit = 1;
  localparam int unsigned HoldIdExBit = 0;
  localparam logic [2:0]  HoldAll     = 3'b111;
  localparam logic [2:0]  HoldNone    = 3'b000;

  // Base opcodes (instr[6:0]).
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcJal    = 7'h6f;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller.
// Arbitrates EX-stage redirects, multi-cycle divides and external bus requests,
// producing PC load, per-stage hold and flush controls.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   jump_en_i/addr_i  EX taken branch/JAL and its target
//   div_start_i       EX issued a divide; div_done_i result-valid pulse
//   bus_req_i         external master bus request; bus_gnt_o grant (registered)
//   pc_load_o/addr_o  PC redirect
//   hold_o            {pc, if_id, id_ex} stall bits
//   flush_if_id_o     IF/ID loads NOP; flush_id_ex_o ID/EX loads NOP
//   div_err_o         one-cycle divide-timeout pulse
`timescale 1ns/1ps
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DIV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        bus_req_i,
  output logic        bus_gnt_o,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic [2:0]  hold_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        div_err_o
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);
  // Last DIV_WAIT cycle index (counter starts at 0 on entry).
  localparam logic [7:0] DivLast   = 8'(DIV_TIMEOUT - 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    div_cnt_d      = div_cnt_q;
    bus_gnt_o      = 1'b0;
    pc_load_o      = 1'b0;
    pc_load_addr_o = '0;
    hold_o         = HoldNone;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    div_err_o      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (jump_en_i) begin
          pc_load_o      = 1'b1;
          pc_load_addr_o = jump_addr_i;
          flush_if_id_o  = 1'b1;
          flush_id_ex_o  = 1'b1;
          flush_cnt_d    = FlushLoad;
          state_d        = StFlush;
        end else if (div_start_i) begin
          // Stall starts in the issue cycle so EX keeps the divide.
          hold_o    = HoldAll;
          div_cnt_d = '0;
          state_d   = StDivWait;
        end else if (bus_req_i) begin
          // Leaving BUS_GNT always lands here for a cycle with hold_o clear,
          // so the core retires something between grants.
          state_d = StBusGnt;
        end
      end

      StFlush: begin
        // Covers fetch latency: wrong-path words still arriving get squashed.
        flush_if_id_o = 1'b1;
        if (flush_cnt_q <= 3'd1) begin
          flush_cnt_d = '0;
          state_d     = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      StDivWait: begin
        if (div_done_i) begin
          div_cnt_d = '0;
          state_d   = StRun;
        end else if (div_cnt_q == DivLast) begin
          div_err_o = 1'b1;
          div_cnt_d = '0;
          state_d   = StRun;
        end else begin
          hold_o    = HoldAll;
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      StBusGnt: begin
        // Grant is a pure state decode, i.e. registered.
        bus_gnt_o = 1'b1;
        hold_o    = HoldAll;
        if (!bus_req_i) state_d = StRun;
      end

      default: state_d = StRun;
    endcase

    // Reset forces quiet outputs even though RUN decodes inputs combinationally.
    if (!rst_n) begin
      bus_gnt_o      = 1'b0;
      pc_load_o      = 1'b0;
      pc_load_addr_o = '0;
      hold_o         = HoldNone;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      div_err_o      = 1'b0;
    end
  end

endmodule
